lcd_backlight_fader: RTL
========================

Name: lcd_backlight_fader

Overview:
Downstream consumer of the LCD LED PIO's 1-bit out_port. Turns the on/off enable into a PWM backlight drive with a programmable brightness level and a soft ramp between off and the programmed level. Exposes a small Avalon-MM slave (same zero-wait, combinational-readdata style as the PIO) for level, ramp rate and status, and drives the LCD backlight pin directly.

Parameters:
PWM_BITS, 8, width of duty/level and PWM counter; PWM period = 2^PWM_BITS-1 clocks
PRESCALE_W, 16, width of ramp prescaler / RAMP_DIV register
DEFAULT_LEVEL, 255, LEVEL register reset value
DEFAULT_RAMP_DIV, 1000, RAMP_DIV register reset value (clocks per duty step)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
led_en  in  1  backlight enable from LED PIO out_port (same clock domain, no synchronizer)
address  in  2  Avalon register select
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational from address
backlight_pwm  out  1  registered PWM drive to backlight
ramping  out  1  high while duty != target

Behaviour:
- Reset: clk, reset_n asynchronous active-low; duty=0, pwm counter=0, prescaler=0, latched duty=0, backlight_pwm=0, ramping=0, LEVEL=DEFAULT_LEVEL, RAMP_DIV=DEFAULT_RAMP_DIV, state=IDLE.
- Write occurs when chipselect && !write_n, takes effect next clock edge.
- addr0 LEVEL: R/W, writedata[PWM_BITS-1:0]; upper bits ignored, read as 0.
- addr1 RAMP_DIV: R/W, writedata[PRESCALE_W-1:0]; any write clears prescaler to 0.
- addr2 STATUS: RO; [PWM_BITS-1:0]=current duty, [16]=ramping, [17]=led_en, others 0; writes ignored.
- addr3: reads 0, writes ignored.
- target = led_en ? LEVEL : 0 (combinational).
- FSM states IDLE, UP, DOWN, evaluated every clock:
  - duty==target -> IDLE; duty<target -> UP; duty>target -> DOWN.
  - target change mid-ramp reverses/retargets immediately; no wait for ramp completion.
- Prescaler: counts 0..RAMP_DIV-1 while state!=IDLE, held at 0 in IDLE; tick when prescaler==RAMP_DIV-1 -> prescaler back to 0.
- On tick: UP -> duty+1, DOWN -> duty-1; duty never passes target, never wraps (saturating at 0 and 2^PWM_BITS-1).
- RAMP_DIV==0: instant mode, duty<=target on the next clock, prescaler unused.
- ramping = (duty != target), registered with state.
- PWM counter: free-running 0..2^PWM_BITS-2, wraps to 0 (period 255 for default).
- latched duty: loaded from duty when counter==0 (glitch-free duty change at period boundary).
- backlight_pwm <= (counter < latched duty); duty 0 -> constant 0; duty 2^PWM_BITS-1 -> constant 1.
- Latency: led_en rise at edge t -> state UP after edge t+1; first duty increment RAMP_DIV clocks later; PWM output reflects new duty from the next counter wrap.
- LEVEL written below current duty while led_en=1 -> ramp DOWN to new LEVEL.
- Reset asserted mid-ramp -> all state cleared immediately, output low.

Test Plan:
- Reset defaults: release reset_n with led_en=0 -> backlight_pwm=0, ramping=0; read addr0=255, addr1=1000, addr2=0.
- Instant on: write RAMP_DIV=0, LEVEL=128, raise led_en -> duty=128 one clock later; after one counter wrap, pwm high exactly 128 of every 255 clocks.
- Soft ramp: RAMP_DIV=4, LEVEL=10, led_en 0->1 -> duty steps 1 every 4 clocks, reaches 10 in 40 clocks (+1 entry), ramping then drops to 0; STATUS[7:0]=10.
- Reversal: RAMP_DIV=4, LEVEL=200, ramp up to duty=20 then drop led_en -> duty counts down from 20 to 0 without overshoot, ramping low at 0.
- Extremes: LEVEL=255 instant -> pwm constant 1 over 3 periods; LEVEL=0 -> constant 0; write to addr2/addr3 -> no register change, addr3 reads 0.
- Reset mid-ramp: assert reset_n low during UP at duty=50 -> pwm=0, duty=0, LEVEL back to 255 immediately, asynchronously.

Source files
------------

// File: rtl/lcd_backlight_fader_if.sv
// Avalon-MM slave bus bundle for the LCD backlight fader register block.
// Zero-wait-state, readdata driven combinationally from address by the slave.
interface lcd_backlight_fader_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_backlight_fader.sv
// PWM backlight driver: ramps duty between 0 and a programmed LEVEL when the
// LED PIO enable toggles, with LEVEL/RAMP_DIV/STATUS exposed over Avalon-MM.
module lcd_backlight_fader #(
    parameter int PWM_BITS         = 8,
    parameter int PRESCALE_W       = 16,
    parameter int DEFAULT_LEVEL    = 255,
    parameter int DEFAULT_RAMP_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  led_en,
    lcd_backlight_fader_if.slave  bus,
    output logic                  backlight_pwm,
    output logic                  ramping
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [PWM_BITS-1:0]   DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]   DUTY_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0]   DUTY_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]   CNT_LAST  = DUTY_MAX - DUTY_ONE;
    localparam logic [PWM_BITS-1:0]   LEVEL_RST = PWM_BITS'(DEFAULT_LEVEL);
    localparam logic [PRESCALE_W-1:0] PRE_ZERO  = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE   = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] RDIV_RST  = PRESCALE_W'(DEFAULT_RAMP_DIV);

    logic [PWM_BITS-1:0]   level_r;
    logic [PRESCALE_W-1:0] ramp_div_r;
    logic [PWM_BITS-1:0]   duty_r;
    logic [PWM_BITS-1:0]   duty_latched_r;
    logic [PWM_BITS-1:0]   pwm_cnt_r;
    logic [PRESCALE_W-1:0] presc_r;
    logic [1:0]            state_r;
    logic                  ramping_r;
    logic                  pwm_r;

    logic                  wr_s;
    logic [PWM_BITS-1:0]   target_s;
    logic [1:0]            state_nxt_s;
    logic [PRESCALE_W-1:0] presc_nxt_s;
    logic [PWM_BITS-1:0]   duty_nxt_s;
    logic                  tick_s;
    logic [31:0]           readdata_s;
    logic                  unused_wdata_s;

    assign wr_s           = bus.chipselect && !bus.write_n;
    assign unused_wdata_s = &{1'b0, bus.writedata};

    // Ramp target follows the PIO enable.
    always_comb begin
        target_s = DUTY_ZERO;
        if (led_en) begin
            target_s = level_r;
        end else begin
            target_s = DUTY_ZERO;
        end
    end

    // Direction is re-decided every clock so a retarget reverses immediately.
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (duty_r == target_s) begin
            state_nxt_s = ST_IDLE;
        end else if (duty_r < target_s) begin
            state_nxt_s = ST_UP;
        end else begin
            state_nxt_s = ST_DOWN;
        end
    end

    // Prescaler and duty stepping; RAMP_DIV of zero jumps straight to target.
    always_comb begin
        presc_nxt_s = presc_r;
        duty_nxt_s  = duty_r;
        tick_s      = 1'b0;
        if (ramp_div_r == PRE_ZERO) begin
            presc_nxt_s = PRE_ZERO;
            duty_nxt_s  = target_s;
        end else if ((state_r == ST_IDLE) || (duty_r == target_s)) begin
            presc_nxt_s = PRE_ZERO;
        end else if (presc_r == (ramp_div_r - PRE_ONE)) begin
            presc_nxt_s = PRE_ZERO;
            tick_s      = 1'b1;
        end else begin
            presc_nxt_s = presc_r + PRE_ONE;
        end

        // The compare against target keeps a stale direction from overshooting.
        if (tick_s && (state_r == ST_UP) && (duty_r < target_s) && (duty_r != DUTY_MAX)) begin
            duty_nxt_s = duty_r + DUTY_ONE;
        end else if (tick_s && (state_r == ST_DOWN) && (duty_r > target_s) && (duty_r != DUTY_ZERO)) begin
            duty_nxt_s = duty_r - DUTY_ONE;
        end else begin
            duty_nxt_s = duty_nxt_s;
        end
    end

    // Programmable registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r    <= LEVEL_RST;
            ramp_div_r <= RDIV_RST;
        end else if (wr_s && (bus.address == 2'd0)) begin
            level_r    <= bus.writedata[PWM_BITS-1:0];
        end else if (wr_s && (bus.address == 2'd1)) begin
            ramp_div_r <= bus.writedata[PRESCALE_W-1:0];
        end else begin
            level_r    <= level_r;
            ramp_div_r <= ramp_div_r;
        end
    end

    // Ramp state: FSM, prescaler, duty and the ramping flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRE_ZERO;
            duty_r    <= DUTY_ZERO;
            ramping_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            duty_r    <= duty_nxt_s;
            ramping_r <= (duty_r != target_s);
            if (wr_s && (bus.address == 2'd1)) begin
                presc_r <= PRE_ZERO;
            end else begin
                presc_r <= presc_nxt_s;
            end
        end
    end

    // PWM generator; duty is sampled only at the period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_r      <= DUTY_ZERO;
            duty_latched_r <= DUTY_ZERO;
            pwm_r          <= 1'b0;
        end else begin
            pwm_cnt_r      <= (pwm_cnt_r == CNT_LAST) ? DUTY_ZERO : (pwm_cnt_r + DUTY_ONE);
            duty_latched_r <= (pwm_cnt_r == DUTY_ZERO) ? duty_r : duty_latched_r;
            pwm_r          <= (pwm_cnt_r < duty_latched_r);
        end
    end

    // Register read mux.
    always_comb begin
        readdata_s = 32'd0;
        case (bus.address)
            2'd0: readdata_s[PWM_BITS-1:0]   = level_r;
            2'd1: readdata_s[PRESCALE_W-1:0] = ramp_div_r;
            2'd2: begin
                readdata_s[PWM_BITS-1:0] = duty_r;
                readdata_s[16]           = ramping_r;
                readdata_s[17]           = led_en;
            end
            default: readdata_s = 32'd0;
        endcase
    end

    assign bus.readdata  = readdata_s;
    assign backlight_pwm = pwm_r;
    assign ramping       = ramping_r;

endmodule
